// File: rtl/encoder4to2_serial.sv
// Sequential 4-to-2 encoder. It accepts one request vector and then emits the index
// of each set bit, one per output handshake, in a fixed priority order.
module encoder4to2_serial #(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i,
    input  logic       i_valid,
    output logic       i_ready,
    output logic [1:0] o,
    output logic       o_valid,
    input  logic       o_ready,
    output logic       o_last,
    output logic       none
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] p;
    logic [3:0] p_next;
    logic       none_next;
    logic [1:0] idx;
    logic       single;

    // Priority pick over the bits that have not been emitted yet.
    always_comb begin
        idx = 2'd0;
        if (HIGH_FIRST) begin
            if (p[3])      idx = 2'd3;
            else if (p[2]) idx = 2'd2;
            else if (p[1]) idx = 2'd1;
            else           idx = 2'd0;
        end else begin
            if (p[0])      idx = 2'd0;
            else if (p[1]) idx = 2'd1;
            else if (p[2]) idx = 2'd2;
            else if (p[3]) idx = 2'd3;
            else           idx = 2'd0;
        end
    end

    // A nonzero value with its lowest set bit cleared is zero only when one bit is set.
    assign single = (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            p     <= 4'b0000;
            none  <= 1'b0;
        end else begin
            state <= state_next;
            p     <= p_next;
            none  <= none_next;
        end
    end

    always_comb begin
        state_next = state;
        p_next     = p;
        none_next  = 1'b0;
        i_ready    = 1'b0;
        o_valid    = 1'b0;
        o          = 2'b00;
        o_last     = 1'b0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    if (i == 4'b0000) begin
                        none_next = 1'b1;
                    end else begin
                        p_next     = i;
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                o_valid = 1'b1;
                o       = idx;
                o_last  = single;
                if (o_ready) begin
                    p_next = p & ~(4'b0001 << idx);
                    // The last index returns to IDLE; a new vector is only taken on the next edge.
                    if (single) begin
                        p_next     = 4'b0000;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                p_next     = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_encoder4to2_serial.sv
// Self-checking bench for encoder4to2_serial. Both priority orders run side by side
// on shared stimulus and are checked against a queue-based model of the expected index lists.
module tb_encoder4to2_serial;

    logic       clk;
    logic       rst;
    logic [3:0] i;
    logic       i_valid;
    logic       o_ready;

    logic       i_ready_lo, o_valid_lo, o_last_lo, none_lo;
    logic [1:0] o_lo;
    logic       i_ready_hi, o_valid_hi, o_last_hi, none_hi;
    logic [1:0] o_hi;

    int checks   = 0;
    int failures = 0;

    int q_lo[$];
    int q_hi[$];
    bit none_exp;

    encoder4to2_serial #(.HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready_lo),
        .o(o_lo), .o_valid(o_valid_lo), .o_ready(o_ready), .o_last(o_last_lo), .none(none_lo)
    );

    encoder4to2_serial #(.HIGH_FIRST(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready_hi),
        .o(o_hi), .o_valid(o_valid_hi), .o_ready(o_ready), .o_last(o_last_hi), .none(none_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an accepted vector becomes the list of its set-bit indices in each order.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_lo.delete();
            q_hi.delete();
            none_exp = 1'b0;
        end else begin
            bit none_nxt;
            none_nxt = 1'b0;
            if (q_lo.size() == 0) begin
                if (i_valid) begin
                    if (i == 4'b0000) begin
                        none_nxt = 1'b1;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (i[b]) begin
                                q_lo.push_back(b);
                                q_hi.push_front(b);
                            end
                        end
                    end
                end
            end else if (o_ready) begin
                void'(q_lo.pop_front());
                void'(q_hi.pop_front());
            end
            none_exp = none_nxt;
        end
    end

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic       ev;
        logic [1:0] e_lo, e_hi;
        ev   = (q_lo.size() > 0);
        e_lo = ev ? 2'(q_lo[0]) : 2'b00;
        e_hi = ev ? 2'(q_hi[0]) : 2'b00;
        cmp({tag, ".o_valid_lo"}, {3'b0, o_valid_lo}, {3'b0, ev});
        cmp({tag, ".o_lo"},       {2'b0, o_lo},       {2'b0, e_lo});
        cmp({tag, ".o_last_lo"},  {3'b0, o_last_lo},  {3'b0, (q_lo.size() == 1)});
        cmp({tag, ".i_ready_lo"}, {3'b0, i_ready_lo}, {3'b0, ~ev});
        cmp({tag, ".none_lo"},    {3'b0, none_lo},    {3'b0, none_exp});
        cmp({tag, ".o_valid_hi"}, {3'b0, o_valid_hi}, {3'b0, ev});
        cmp({tag, ".o_hi"},       {2'b0, o_hi},       {2'b0, e_hi});
        cmp({tag, ".o_last_hi"},  {3'b0, o_last_hi},  {3'b0, (q_hi.size() == 1)});
        cmp({tag, ".i_ready_hi"}, {3'b0, i_ready_hi}, {3'b0, ~ev});
        cmp({tag, ".none_hi"},    {3'b0, none_hi},    {3'b0, none_exp});
    endtask

    // Drive inputs after the falling edge, let the rising edge act, check at the next falling edge.
    task automatic applyStimulus(input logic [3:0] v, input logic vld, input logic rdy, input string tag);
        i       = v;
        i_valid = vld;
        o_ready = rdy;
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic lit(input string name, input logic [1:0] lo, input logic [1:0] hi,
                       input logic vld, input logic last);
        cmp({name, ".lit_valid"}, {3'b0, o_valid_lo}, {3'b0, vld});
        cmp({name, ".lit_o_lo"},  {2'b0, o_lo},       {2'b0, lo});
        cmp({name, ".lit_o_hi"},  {2'b0, o_hi},       {2'b0, hi});
        cmp({name, ".lit_last"},  {3'b0, o_last_lo},  {3'b0, last});
    endtask

    initial begin
        rst = 1'b1; i = 4'b0000; i_valid = 1'b0; o_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset");
        lit("reset", 2'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        applyStimulus(4'b1011, 1'b1, 1'b1, "t1a"); lit("t1a", 2'd0, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t1b"); lit("t1b", 2'd1, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t1c"); lit("t1c", 2'd3, 2'd0, 1'b1, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t1d"); cmp("t1d.lit_i_ready", {3'b0, i_ready_lo}, 4'd1);

        applyStimulus(4'b0110, 1'b1, 1'b0, "t2a"); lit("t2a", 2'd1, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, "t2b"); lit("t2b", 2'd1, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, "t2c"); lit("t2c", 2'd1, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t2d"); lit("t2d", 2'd2, 2'd1, 1'b1, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t2e"); lit("t2e", 2'd0, 2'd0, 1'b0, 1'b0);

        applyStimulus(4'b0000, 1'b1, 1'b1, "t3a");
        cmp("t3a.lit_none", {3'b0, none_lo}, 4'd1);
        cmp("t3a.lit_i_ready", {3'b0, i_ready_lo}, 4'd1);
        lit("t3a", 2'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t3b");
        cmp("t3b.lit_none", {3'b0, none_hi}, 4'd0);

        applyStimulus(4'b1111, 1'b1, 1'b1, "t4a"); lit("t4a", 2'd0, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t4b"); lit("t4b", 2'd1, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t4c"); lit("t4c", 2'd2, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t4d"); lit("t4d", 2'd3, 2'd0, 1'b1, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1, "t4e");

        applyStimulus(4'b1111, 1'b1, 1'b1, "t5a");
        applyStimulus(4'b0000, 1'b0, 1'b1, "t5b"); lit("t5b", 2'd1, 2'd2, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 checkOutput("t5rst");
        lit("t5rst", 2'd0, 2'd0, 1'b0, 1'b0);
        cmp("t5rst.lit_valid_hi", {3'b0, o_valid_hi}, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b1, "t5c");
        lit("t5c", 2'd0, 2'd0, 1'b0, 1'b0);
        cmp("t5c.lit_i_ready", {3'b0, i_ready_hi}, 4'd1);

        for (int k = 0; k < 4; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << k;
            applyStimulus(oh, 1'b1, 1'b1, "t6a"); lit("t6a", 2'(k), 2'(k), 1'b1, 1'b1);
            applyStimulus(4'b1111, 1'b1, 1'b1, "t6b"); lit("t6b", 2'd0, 2'd0, 1'b0, 1'b0);
        end

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1 checkOutput("rnd_rst");
                @(negedge clk);
                rst = 1'b0;
            end
            applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) != 0), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
